// File: rtl/alu_main.sv
// ----------------------------------------------------------------------------
// alu_main
// Execute-stage ALU for a multi-cycle, non-pipelined MIPS datapath.
// Operand B is either the register-file B port or the pre-extended immediate.
// The selected operation runs combinationally and is captured into the
// ALU-out register and flag registers on every rising clock edge.
//
// Ports
//   Clk          in   1       system clock, rising-edge
//   Reset        in   1       asynchronous, active-high
//   RF_A         in   WIDTH   operand A
//   RF_B         in   WIDTH   register-file read port B
//   Immed        in   WIDTH   immediate, already extended by decode
//   ALU_Bin_sel  in   1       0: B = RF_B, 1: B = Immed
//   ALU_func     in   4       operation select
//   ALU_out      out  WIDTH   registered result
//   Zero         out  1       registered, latched result == 0
//   Ovf          out  1       registered, signed overflow of add/sub
//   Cout         out  1       registered, add carry / sub no-borrow
// ----------------------------------------------------------------------------
module alu_main #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] RF_A,
    input  logic [WIDTH-1:0] RF_B,
    input  logic [WIDTH-1:0] Immed,
    input  logic             ALU_Bin_sel,
    input  logic [3:0]       ALU_func,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Zero,
    output logic             Ovf,
    output logic             Cout
);

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b0001;
    localparam logic [3:0] FUNC_OR   = 4'b0010;
    localparam logic [3:0] FUNC_AND  = 4'b0011;
    localparam logic [3:0] FUNC_NOTA = 4'b0100;
    localparam logic [3:0] FUNC_NAND = 4'b0101;
    localparam logic [3:0] FUNC_NOR  = 4'b0110;
    localparam logic [3:0] FUNC_XOR  = 4'b0111;
    localparam logic [3:0] FUNC_SRA  = 4'b1000;
    localparam logic [3:0] FUNC_SRL  = 4'b1001;
    localparam logic [3:0] FUNC_SLL  = 4'b1010;
    localparam logic [3:0] FUNC_ROL  = 4'b1100;
    localparam logic [3:0] FUNC_ROR  = 4'b1101;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_cout;

    logic [WIDTH-1:0] r_alu_out;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;

    assign w_b = ALU_Bin_sel ? Immed : RF_B;

    // Subtraction is formed as A + ~B + 1 so that the top bit is the
    // "no borrow" carry rather than a borrow.
    assign w_sum  = {1'b0, RF_A} + {1'b0, w_b};
    assign w_diff = {1'b0, RF_A} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        w_cout   = 1'b0;
        unique case (ALU_func)
            FUNC_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_cout   = w_sum[WIDTH];
                w_ovf    = (RF_A[WIDTH-1] == w_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != RF_A[WIDTH-1]);
            end
            FUNC_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_cout   = w_diff[WIDTH];
                w_ovf    = (RF_A[WIDTH-1] != w_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != RF_A[WIDTH-1]);
            end
            FUNC_OR:   w_result = RF_A | w_b;
            FUNC_AND:  w_result = RF_A & w_b;
            FUNC_NOTA: w_result = ~RF_A;
            FUNC_NAND: w_result = ~(RF_A & w_b);
            FUNC_NOR:  w_result = ~(RF_A | w_b);
            FUNC_XOR:  w_result = RF_A ^ w_b;
            FUNC_SRA:  w_result = {RF_A[WIDTH-1], RF_A[WIDTH-1:1]};
            FUNC_SRL:  w_result = {1'b0, RF_A[WIDTH-1:1]};
            FUNC_SLL:  w_result = {RF_A[WIDTH-2:0], 1'b0};
            FUNC_ROL:  w_result = {RF_A[WIDTH-2:0], RF_A[WIDTH-1]};
            FUNC_ROR:  w_result = {RF_A[0], RF_A[WIDTH-1:1]};
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_alu_out <= '0;
            r_zero    <= 1'b1;
            r_ovf     <= 1'b0;
            r_cout    <= 1'b0;
        end else begin
            r_alu_out <= w_result;
            r_zero    <= (w_result == '0);
            r_ovf     <= w_ovf;
            r_cout    <= w_cout;
        end
    end

    assign ALU_out = r_alu_out;
    assign Zero    = r_zero;
    assign Ovf     = r_ovf;
    assign Cout    = r_cout;

endmodule

// File: tb/tb_alu_main.sv
module tb_alu_main;

    logic        Clk;
    logic        Reset;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [31:0] Immed;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic [31:0] ALU_out;
    logic        Zero;
    logic        Ovf;
    logic        Cout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        c;
    } exp_t;

    exp_t exp_q[$];

    alu_main #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .RF_A       (RF_A),
        .RF_B       (RF_B),
        .Immed      (Immed),
        .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func   (ALU_func),
        .ALU_out    (ALU_out),
        .Zero       (Zero),
        .Ovf        (Ovf),
        .Cout       (Cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_now(input string name, input logic [31:0] res,
                             input logic z, input logic o, input logic c);
        n_checks++;
        if (ALU_out !== res || Zero !== z || Ovf !== o || Cout !== c) begin
            n_errors++;
            $display("FAIL %s: got out=%h z=%b o=%b c=%b, want out=%h z=%b o=%b c=%b",
                     name, ALU_out, Zero, Ovf, Cout, res, z, o, c);
        end
    endtask

    // Monitor: the DUT presents a fresh result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e.name, e.res, e.z, e.o, e.c);
            end
        end
    end

    task automatic apply(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic sel, input logic [3:0] func,
                         input logic [31:0] res, input logic z,
                         input logic o, input logic c);
        exp_t e;
        @(negedge Clk);
        RF_A        = a;
        RF_B        = b;
        Immed       = imm;
        ALU_Bin_sel = sel;
        ALU_func    = func;
        e.name = name;
        e.res  = res;
        e.z    = z;
        e.o    = o;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset       = 1'b1;
        RF_A        = 32'h1234_5678;
        RF_B        = 32'h0000_0001;
        Immed       = 32'h0000_0002;
        ALU_Bin_sel = 1'b0;
        ALU_func    = 4'b0000;

        #2;
        check_now("reset_initial", 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check_now("reset_hold", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        apply("or",       32'h884E2B59, 32'h739D2C40, 32'h0,        1'b0, 4'b0010, 32'hFBDF2F59, 1'b0, 1'b0, 1'b0);
        apply("add_imm",  32'hE84CEF61, 32'hFFFFFFFF, 32'h0000DD8F, 1'b1, 4'b0000, 32'hE84DCCF0, 1'b0, 1'b0, 1'b0);
        apply("add_ovf",  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h80000000, 1'b0, 1'b1, 1'b0);
        apply("sub_zero", 32'h00000005, 32'h00000005, 32'h0,        1'b0, 4'b0001, 32'h00000000, 1'b1, 1'b0, 1'b1);
        apply("sub_brw",  32'h00000003, 32'h00000005, 32'h0,        1'b0, 4'b0001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        apply("sub_ovf",  32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 4'b0001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        apply("add_wrap", 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1);
        apply("and",      32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b0, 4'b0011, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        apply("not_a",    32'hFFFFFFFF, 32'h12345678, 32'h0,        1'b0, 4'b0100, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply("nand",     32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b0, 4'b0101, 32'hFF0FFF0F, 1'b0, 1'b0, 1'b0);
        apply("nor",      32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        1'b0, 4'b0110, 32'h00000F0F, 1'b0, 1'b0, 1'b0);
        apply("xor",      32'hAAAA5555, 32'h0,        32'hFFFF0000, 1'b1, 4'b0111, 32'h55555555, 1'b0, 1'b0, 1'b0);
        apply("sra",      32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1000, 32'hC0000000, 1'b0, 1'b0, 1'b0);
        apply("srl",      32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1001, 32'h40000000, 1'b0, 1'b0, 1'b0);
        apply("sll",      32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1010, 32'h00000002, 1'b0, 1'b0, 1'b0);
        apply("rol",      32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1100, 32'h00000003, 1'b0, 1'b0, 1'b0);
        apply("ror",      32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1101, 32'hC0000000, 1'b0, 1'b0, 1'b0);
        apply("f1011",    32'h80000001, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1011, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply("f1110",    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b1110, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply("f1111",    32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 4'b1111, 32'h00000000, 1'b1, 1'b0, 1'b0);
        apply("sel_rfb",  32'h0000000A, 32'h00000001, 32'h00000002, 1'b0, 4'b0000, 32'h0000000B, 1'b0, 1'b0, 1'b0);
        apply("sel_imm",  32'h0000000A, 32'h00000001, 32'h00000002, 1'b1, 4'b0000, 32'h0000000C, 1'b0, 1'b0, 1'b0);

        // Inputs changed between edges must not disturb the latched result.
        @(posedge Clk);
        #3;
        RF_A     = 32'hDEADBEEF;
        ALU_func = 4'b0100;
        #1;
        check_now("hold_between_edges", 32'h0000000C, 1'b0, 1'b0, 1'b0);

        // Capture a result with flags set, then assert reset mid-cycle.
        apply("pre_reset", 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 4'b0000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check_now("reset_async", 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        check_now("reset_hold_mid", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        apply("post_reset", 32'h00000010, 32'h00000004, 32'h0, 1'b0, 4'b0001, 32'h0000000C, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
